// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream carrying {pc, data} between adjacent pipeline stages.
//  master: drives valid, pc, data; samples ready
//  slave : samples valid, pc, data; drives ready
interface pipe_stage_skid_if #(
   parameter int unsigned PC_W   = 8,
   parameter int unsigned DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic [PC_W-1:0]   pc;
   logic [DATA_W-1:0] data;

   modport master (output valid, output pc, output data, input ready);
   modport slave  (input valid, input pc, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, branch-squash flush
// and a saturating stall counter.
//  clk, reset   : clock, synchronous active-high reset
//  flush        : squash all held entries; an entry offered this cycle is dropped
//  up (slave)   : upstream stream; up.ready = stage not FULL (registered)
//  dn (master)  : downstream stream; dn.pc = 0 and dn.data = NOP_VALUE when invalid
//  occupancy    : entries held (0..2)
//  stall_count  : cycles with dn.valid & !dn.ready, saturating
module pipe_stage_skid #(
   parameter int unsigned         DATA_W    = 32,
   parameter int unsigned         PC_W      = 8,
   parameter logic [DATA_W-1:0]   NOP_VALUE = '0,
   parameter int unsigned         CNT_W     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   pipe_stage_skid_if.slave        up,
   pipe_stage_skid_if.master       dn,
   output logic [1:0]              occupancy,
   output logic [CNT_W-1:0]        stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   main_pc_q, main_pc_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              accept;
   logic              pop;

   // Next-state, datapath and counter update
   always_comb begin
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_data_d = main_data_q;
      skid_pc_d   = skid_pc_q;
      skid_data_d = skid_data_q;
      stall_d     = stall_q;
      accept      = up.valid & in_ready_q;
      pop         = out_valid_q & dn.ready;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_pc_d   = up.pc;
               main_data_d = up.data;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               main_pc_d   = up.pc;
               main_data_d = up.data;
            end else if (accept) begin
               skid_pc_d   = up.pc;
               skid_data_d = up.data;
               state_d     = ST_FULL;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               main_pc_d   = skid_pc_q;
               main_data_d = skid_data_q;
               state_d     = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Squash wins over any transfer; an accepted entry is simply not stored
      if (flush) state_d = ST_EMPTY;

      // Park the head at the idle pattern so dn.* stay fully registered
      if (state_d == ST_EMPTY) begin
         main_pc_d   = '0;
         main_data_d = NOP_VALUE;
      end

      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_FULL);

      if (out_valid_q && !dn.ready && (stall_q != CNT_MAX))
         stall_d = stall_q + CNT_W'(1);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_pc_q   <= '0;
         main_data_q <= NOP_VALUE;
         skid_pc_q   <= '0;
         skid_data_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         main_pc_q   <= main_pc_d;
         main_data_q <= main_data_d;
         skid_pc_q   <= skid_pc_d;
         skid_data_q <= skid_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         stall_q     <= stall_d;
      end
   end

   assign up.ready    = in_ready_q;
   assign dn.valid    = out_valid_q;
   assign dn.pc       = main_pc_q;
   assign dn.data     = main_data_q;
   assign occupancy   = state_q;
   assign stall_count = stall_q;

endmodule
